// File: rtl/led_counter.sv
// led_counter: debounced up/down/mode buttons drive a saturating 0..16 count.
// A mode button toggles between manual stepping and an auto up/down sweep.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   btn_up/down/mode raw active-high buttons, asynchronous to clk
//   counter_out      registered count 0..16 for the LED thermometer
//   at_max, at_min   count is 16 / count is 0
//   mode_auto        FSM is sweeping (AUTO_UP or AUTO_DOWN)
module led_counter #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TICK_DIV        = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_mode,
    output logic [4:0] counter_out,
    output logic       at_max,
    output logic       at_min,
    output logic       mode_auto
);

    localparam int SW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TW = $clog2(TICK_DIV);
    localparam logic [SW-1:0] STAB_LAST = SW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        MANUAL    = 2'd0,
        AUTO_UP   = 2'd1,
        AUTO_DOWN = 2'd2
    } state_t;

    state_t        state;
    logic [2:0]    raw;
    logic [2:0]    sync1;
    logic [2:0]    sync2;
    logic [2:0]    deb;
    logic [2:0]    deb_q;
    logic [2:0]    press;
    logic [SW-1:0] stab [3];
    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic          press_up;
    logic          press_down;
    logic          press_mode;

    // Bit order is shared by every per-button vector below.
    assign raw = {btn_mode, btn_down, btn_up};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // The debounced level follows the synchronized level only after
    // DEBOUNCE_CYCLES consecutive cycles of disagreement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb   <= '0;
            deb_q <= '0;
            for (int i = 0; i < 3; i++) begin
                stab[i] <= '0;
            end
        end else begin
            deb_q <= deb;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == deb[i]) begin
                    stab[i] <= '0;
                end else if (stab[i] == STAB_LAST) begin
                    stab[i] <= '0;
                    deb[i]  <= sync2[i];
                end else begin
                    stab[i] <= stab[i] + SW'(1);
                end
            end
        end
    end

    assign press      = deb & ~deb_q;
    assign press_up   = press[0];
    assign press_down = press[1];
    assign press_mode = press[2];

    assign tick = (state != MANUAL) && (tick_cnt == TICK_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= MANUAL;
            counter_out <= '0;
            tick_cnt    <= '0;
        end else begin
            unique case (state)
                MANUAL: begin
                    tick_cnt <= '0;
                    if (press_mode) begin
                        state <= AUTO_UP;
                    end else if (press_up && !press_down) begin
                        if (counter_out < 5'd16) begin
                            counter_out <= counter_out + 5'd1;
                        end
                    end else if (press_down && !press_up) begin
                        if (counter_out != 5'd0) begin
                            counter_out <= counter_out - 5'd1;
                        end
                    end
                end
                AUTO_UP: begin
                    if (press_mode) begin
                        state    <= MANUAL;
                        tick_cnt <= '0;
                    end else if (tick) begin
                        tick_cnt <= '0;
                        // Entered already at 16: turn around at once.
                        if (counter_out >= 5'd16) begin
                            state       <= AUTO_DOWN;
                            counter_out <= 5'd15;
                        end else begin
                            counter_out <= counter_out + 5'd1;
                            if (counter_out == 5'd15) begin
                                state <= AUTO_DOWN;
                            end
                        end
                    end else begin
                        tick_cnt <= tick_cnt + TW'(1);
                    end
                end
                AUTO_DOWN: begin
                    if (press_mode) begin
                        state    <= MANUAL;
                        tick_cnt <= '0;
                    end else if (tick) begin
                        tick_cnt <= '0;
                        if (counter_out == 5'd0) begin
                            state       <= AUTO_UP;
                            counter_out <= 5'd1;
                        end else begin
                            counter_out <= counter_out - 5'd1;
                            if (counter_out == 5'd1) begin
                                state <= AUTO_UP;
                            end
                        end
                    end else begin
                        tick_cnt <= tick_cnt + TW'(1);
                    end
                end
                default: begin
                    state    <= MANUAL;
                    tick_cnt <= '0;
                end
            endcase
        end
    end

    assign at_max    = (counter_out == 5'd16);
    assign at_min    = (counter_out == 5'd0);
    assign mode_auto = (state != MANUAL);

endmodule

// File: tb/tb_led_counter.sv
// tb_led_counter: table of clean presses plus hand-written
// latency, glitch, auto-sweep and reset sequences.
module tb_led_counter;

    localparam int DEB  = 4;
    localparam int TDIV = 8;
    localparam int HOLD = 12;

    logic       clk;
    logic       rst_n;
    logic       btn_up;
    logic       btn_down;
    logic       btn_mode;
    logic [4:0] counter_out;
    logic       at_max;
    logic       at_min;
    logic       mode_auto;

    int total;
    int bad;

    typedef struct {
        logic       up;
        logic       down;
        logic [4:0] cnt;
    } vec_t;

    vec_t       vecs[$];
    vec_t       exp_q[$];
    logic [4:0] auto_q[$];

    led_counter #(
        .DEBOUNCE_CYCLES(DEB),
        .TICK_DIV(TDIV)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .btn_up(btn_up),
        .btn_down(btn_down),
        .btn_mode(btn_mode),
        .counter_out(counter_out),
        .at_max(at_max),
        .at_min(at_min),
        .mode_auto(mode_auto)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk5(input string name, input logic [4:0] act,
                        input logic [4:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act,
                        input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic flags(input string name, input logic [4:0] c,
                         input logic au);
        chk5({name, " cnt"}, counter_out, c);
        chk1({name, " max"}, at_max, c == 5'd16);
        chk1({name, " min"}, at_min, c == 5'd0);
        chk1({name, " auto"}, mode_auto, au);
    endtask

    task automatic add(input logic u, input logic d, input int c);
        vec_t v;
        v.up   = u;
        v.down = d;
        v.cnt  = 5'(c);
        vecs.push_back(v);
    endtask

    task automatic press(input logic u, input logic d, input logic m);
        @(negedge clk);
        btn_up   = u;
        btn_down = d;
        btn_mode = m;
        repeat (HOLD) @(negedge clk);
        btn_up   = 1'b0;
        btn_down = 1'b0;
        btn_mode = 1'b0;
        repeat (HOLD) @(negedge clk);
    endtask

    // Raise btn_up, expect the count to move from c0 to c1 at edge DEB+3.
    task automatic latency(input string name, input logic [4:0] c0,
                           input logic [4:0] c1);
        for (int e = 1; e < DEB + 3; e++) begin
            @(posedge clk);
            #1;
            chk5($sformatf("%s edge%0d", name, e), counter_out, c0);
        end
        @(posedge clk);
        #1;
        chk5($sformatf("%s edge%0d", name, DEB + 3), counter_out, c1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t       e;
        int         m_cnt;
        bit         m_up;
        logic [4:0] a;

        total    = 0;
        bad      = 0;
        rst_n    = 1'b1;
        btn_up   = 1'b0;
        btn_down = 1'b0;
        btn_mode = 1'b0;

        for (int k = 1; k <= 17; k++) add(1'b1, 1'b0, (k + 1 > 16) ? 16 : k + 1);
        for (int k = 1; k <= 16; k++) add(1'b0, 1'b1, 16 - k);
        add(1'b0, 1'b1, 0);
        add(1'b1, 1'b1, 0);
        for (int k = 1; k <= 5; k++) add(1'b1, 1'b0, k);
        add(1'b1, 1'b1, 5);
        for (int k = 6; k <= 13; k++) add(1'b1, 1'b0, k);

        #2;
        rst_n = 1'b0;
        #1;
        flags("reset", 5'd0, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Held button: one step at edge 7, nothing more while held.
        @(negedge clk);
        btn_up = 1'b1;
        latency("held", 5'd0, 5'd1);
        repeat (20) @(posedge clk);
        #1;
        chk5("held stays", counter_out, 5'd1);
        @(negedge clk);
        btn_up = 1'b0;
        repeat (HOLD) @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            exp_q.push_back(vecs[i]);
            press(vecs[i].up, vecs[i].down, 1'b0);
            e = exp_q.pop_front();
            flags($sformatf("vec%0d", i), e.cnt, 1'b0);
        end

        // 3-cycle up pulse with 1-cycle down glitches: rejected.
        @(negedge clk);
        btn_up = 1'b1;
        for (int k = 0; k < 12; k++) begin
            btn_down = ~k[0];
            if (k == 3) btn_up = 1'b0;
            @(negedge clk);
        end
        btn_down = 1'b0;
        repeat (HOLD) @(negedge clk);
        flags("glitch", 5'd13, 1'b0);

        // 4-cycle pulse is exactly long enough.
        @(negedge clk);
        btn_up = 1'b1;
        repeat (DEB) @(posedge clk);
        @(negedge clk);
        btn_up = 1'b0;
        repeat (HOLD) @(negedge clk);
        flags("pulse4", 5'd14, 1'b0);

        // Enter auto at 14.
        @(negedge clk);
        btn_mode = 1'b1;
        repeat (DEB + 2) @(posedge clk);
        #1;
        chk1("mode pre", mode_auto, 1'b0);
        @(posedge clk);
        #1;
        chk1("mode entry", mode_auto, 1'b1);
        chk5("mode entry cnt", counter_out, 5'd14);
        btn_mode = 1'b0;

        m_cnt = 14;
        m_up  = 1'b1;
        for (int s = 1; s <= 27; s++) begin
            if (s == 3) btn_up = 1'b1;
            if (s == 6) btn_up = 1'b0;
            if (s == 10) btn_down = 1'b1;
            if (s == 12) btn_down = 1'b0;
            if (s == 14) btn_up = 1'b1;
            if (s == 15) btn_up = 1'b0;
            repeat (TDIV - 1) @(posedge clk);
            #1;
            chk5($sformatf("auto%0d hold", s), counter_out, 5'(m_cnt));
            if (m_up) begin
                m_cnt++;
                if (m_cnt == 16) m_up = 1'b0;
            end else begin
                m_cnt--;
                if (m_cnt == 0) m_up = 1'b1;
            end
            auto_q.push_back(5'(m_cnt));
            @(posedge clk);
            #1;
            a = auto_q.pop_front();
            flags($sformatf("auto%0d", s), a, 1'b1);
        end

        // Exit at 9, then the count stays frozen.
        btn_mode = 1'b1;
        repeat (DEB + 3) @(posedge clk);
        #1;
        flags("exit", 5'd9, 1'b0);
        btn_mode = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        flags("frozen", 5'd9, 1'b0);

        // Mode wins over a same-cycle up press.
        @(negedge clk);
        btn_mode = 1'b1;
        btn_up   = 1'b1;
        repeat (DEB + 3) @(posedge clk);
        #1;
        flags("mode+up", 5'd9, 1'b1);
        btn_mode = 1'b0;
        btn_up   = 1'b0;

        // Asynchronous reset mid-auto.
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        flags("async rst", 5'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        btn_up = 1'b1;
        latency("post rst", 5'd0, 5'd1);
        @(negedge clk);
        btn_up = 1'b0;
        repeat (HOLD) @(negedge clk);

        // In-flight press discarded by reset.
        @(negedge clk);
        btn_up = 1'b1;
        repeat (DEB) @(posedge clk);
        @(negedge clk);
        btn_up = 1'b0;
        #1;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        flags("inflight", 5'd0, 1'b0);

        // Button held across reset release: exactly one press.
        @(negedge clk);
        rst_n  = 1'b0;
        btn_up = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        latency("held rst", 5'd0, 5'd1);
        repeat (20) @(posedge clk);
        #1;
        chk5("held rst stays", counter_out, 5'd1);
        @(negedge clk);
        btn_up = 1'b0;
        repeat (HOLD) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/led_counter.md
LED_COUNTER -- requirements
Module: led_counter

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable cycles required to accept a button level change; legal range >= 1.
REQ-002 Parameter TICK_DIV, default 8: clock cycles per auto-mode step; legal range >= 2.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 btn_up  input  1  raw increment button, asynchronous to clk, active-high.
REQ-006 btn_down  input  1  raw decrement button, asynchronous to clk, active-high.
REQ-007 btn_mode  input  1  raw mode-toggle button, asynchronous to clk, active-high.
REQ-008 counter_out  output  5  registered count, 0..16; feeds the LED thermometer decoder.
REQ-009 at_max  output  1  high iff counter_out == 16.
REQ-010 at_min  output  1  high iff counter_out == 0.
REQ-011 mode_auto  output  1  high iff the FSM is in AUTO_UP or AUTO_DOWN.

Function
REQ-012 Each button SHALL pass through a 2-flop synchronizer reset to 0.
REQ-013 Debounce: per button, the debounced level SHALL take the synchronized level only after the two have differed for DEBOUNCE_CYCLES consecutive cycles; any agreement clears the stability count.
REQ-014 Press event: one-cycle pulse when the debounced level goes 0->1; held buttons SHALL produce exactly one press; releases produce none.
REQ-015 Latency: with a clean raw press, counter_out SHALL change on clock edge DEBOUNCE_CYCLES+3, counting the first edge that samples the raw input high as edge 1.
REQ-016 FSM states: MANUAL (reset state), AUTO_UP, AUTO_DOWN.
REQ-017 MANUAL: an up press increments, saturating at 16; a down press decrements, saturating at 0.
REQ-018 MANUAL: up and down presses in the same cycle SHALL leave the count unchanged.
REQ-019 Mode press: MANUAL -> AUTO_UP; AUTO_UP or AUTO_DOWN -> MANUAL.
REQ-020 A mode press SHALL take priority over a same-cycle up/down press; the count is unchanged in that cycle.
REQ-021 Tick counter: counts 0..TICK_DIV-1 and wraps; tick asserts when the value is TICK_DIV-1; it is cleared on every MANUAL -> AUTO_UP transition and held at 0 in MANUAL.
REQ-022 AUTO_UP: on each tick the count increments.
REQ-023 AUTO_UP: on the tick that makes the count 16, the state SHALL become AUTO_DOWN; if the count is already 16 on entry, the first tick moves to AUTO_DOWN and decrements to 15.
REQ-024 AUTO_DOWN: on each tick the count decrements.
REQ-025 AUTO_DOWN: on the tick that makes the count 0, the state SHALL become AUTO_UP.
REQ-026 In both auto states, up/down presses SHALL be ignored.
REQ-027 The first auto step SHALL occur TICK_DIV edges after the edge that entered AUTO_UP.
REQ-028 Leaving auto mode SHALL freeze counter_out at its current value.
REQ-029 counter_out SHALL never exceed 16; values 17..31 are unreachable.
REQ-030 at_max, at_min and mode_auto SHALL be decoded from registered state with no extra latency.

Reset
REQ-031 rst_n low SHALL immediately force: counter_out=0, at_min=1, at_max=0, mode_auto=0, state MANUAL, synchronizers, debounced levels, stability counts and tick counter all 0.
REQ-032 Reset asserted mid-operation SHALL discard any in-flight press.
REQ-033 A button held high across rst_n deassertion SHALL yield exactly one press after the normal latency.

Verification (DEBOUNCE_CYCLES=4, TICK_DIV=8)
REQ-034 Reset; hold btn_up high from edge 1 -> counter_out goes 0 to 1 at edge 7 and stays 1 while held; 17 further clean presses -> counter_out=16, at_max=1.
REQ-035 btn_up pulsed high for 3 cycles, plus 1-cycle glitches on btn_down -> counter_out unchanged.
REQ-036 Down press at count 0 -> stays 0, at_min=1; up and down debounced in the same cycle at count 5 -> stays 5.
REQ-037 Count 14, mode press -> mode_auto=1; counter_out reads 15, 16, 15, ... 0, 1 at 8-cycle spacing; up presses during auto have no effect.
REQ-038 Mode press while auto at count 9 -> mode_auto=0 and counter_out holds 9 indefinitely.
REQ-039 rst_n pulsed low mid-auto at count 9 -> counter_out=0, mode_auto=0 asynchronously; after release a clean up press yields 1 at edge 7.
